// File: rtl/simple_cola_fsm.sv
// Coin-counting vending controller: three single-unit coins buy one cola.
// po_cola pulses for one cycle, registered, when the third coin is sampled.
module simple_cola_fsm (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic pi_money,
    output logic po_cola
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ONE  = 3'b010,
        TWO  = 3'b100
    } state_t;

    state_t state_r;
    state_t state_s;
    logic   cola_s;
    logic   po_cola_r;

    // Next-state and dispense decode; illegal encodings fall back to IDLE without a sale
    always_comb begin
        state_s = state_r;
        cola_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pi_money) begin
                    state_s = ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            ONE: begin
                if (pi_money) begin
                    state_s = TWO;
                end else begin
                    state_s = ONE;
                end
            end
            TWO: begin
                if (pi_money) begin
                    state_s = IDLE;
                    cola_s  = 1'b1;
                end else begin
                    state_s = TWO;
                end
            end
            default: begin
                state_s = IDLE;
                cola_s  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered dispense pulse, so pi_money never reaches po_cola combinationally
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            po_cola_r <= 1'b0;
        end else begin
            po_cola_r <= cola_s;
        end
    end

    assign po_cola = po_cola_r;

endmodule

// File: tb/tb_simple_cola_fsm.sv
// Scoreboard bench for simple_cola_fsm: a coins-mod-3 model queues the expected
// po_cola/state for each driven cycle, popped and compared after the edge.
module tb_simple_cola_fsm;

    logic sys_clk;
    logic sys_rst_n;
    logic pi_money;
    logic po_cola;

    int n_cmp;
    int n_err;
    int model_cnt;
    int pulse_cnt;
    logic prev_cola;
    logic [3:0] exp_q[$];

    simple_cola_fsm dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .pi_money (pi_money),
        .po_cola  (po_cola)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [2:0] enc(input int cnt);
        if (cnt == 0) return 3'b001;
        else if (cnt == 1) return 3'b010;
        else return 3'b100;
    endfunction

    task automatic do_cycle(input logic m, input string name);
        logic [3:0] e;
        logic [2:0] st;
        @(negedge sys_clk);
        pi_money = m;
        e[3] = (model_cnt == 2) && m;
        if (m) model_cnt = (model_cnt == 2) ? 0 : model_cnt + 1;
        e[2:0] = enc(model_cnt);
        exp_q.push_back(e);
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        st = dut.state_r;
        n_cmp++;
        if (po_cola !== e[3]) begin
            n_err++;
            $display("FAIL %s po_cola: got %b want %b", name, po_cola, e[3]);
        end
        n_cmp++;
        if (st !== e[2:0]) begin
            n_err++;
            $display("FAIL %s state: got %b want %b", name, st, e[2:0]);
        end
        if (po_cola === 1'b1) pulse_cnt++;
        n_cmp++;
        if (prev_cola === 1'b1 && po_cola === 1'b1) begin
            n_err++;
            $display("FAIL %s double_pulse: got 11 want not 11", name);
        end
        prev_cola = po_cola;
    endtask

    task automatic apply_reset(input int cycles, input string name);
        logic [2:0] st;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        st = dut.state_r;
        n_cmp++;
        if (po_cola !== 1'b0 || st !== 3'b001) begin
            n_err++;
            $display("FAIL %s async: got cola=%b state=%b want 0/001", name, po_cola, st);
        end
        for (int i = 0; i < cycles; i++) begin
            pi_money = ~pi_money;
            @(posedge sys_clk);
            #1;
            st = dut.state_r;
            n_cmp++;
            if (po_cola !== 1'b0 || st !== 3'b001) begin
                n_err++;
                $display("FAIL %s held: got cola=%b state=%b want 0/001", name, po_cola, st);
            end
            @(negedge sys_clk);
        end
        pi_money  = 1'b0;
        sys_rst_n = 1'b1;
        model_cnt = 0;
        prev_cola = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        pi_money = 1'b0;
        apply_reset(4, "reset");
        for (int i = 0; i < 2; i++) do_cycle(1'b1, "reset_post");
        do_cycle(1'b0, "reset_post");
        do_cycle(1'b1, "reset_post");
        // po_cola is high now; reset mid-cycle must clear it without a clock edge
        n_cmp++;
        if (po_cola !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_async: got %b want 1", po_cola);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (po_cola !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async_clear: got %b want 0", po_cola);
        end
        apply_reset(1, "reset_clear");
    endtask

    task automatic test_separated();
        pulse_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            do_cycle((c == 2 || c == 5 || c == 9) ? 1'b1 : 1'b0, "separated");
        end
        n_cmp++;
        if (pulse_cnt != 1) begin
            n_err++;
            $display("FAIL separated_pulses: got %0d want 1", pulse_cnt);
        end
    endtask

    task automatic test_back_to_back();
        pulse_cnt = 0;
        for (int i = 0; i < 9; i++) do_cycle(1'b1, "back_to_back");
        do_cycle(1'b0, "back_to_back");
        n_cmp++;
        if (pulse_cnt != 3) begin
            n_err++;
            $display("FAIL back_to_back_pulses: got %0d want 3", pulse_cnt);
        end
    endtask

    task automatic test_hold_credit();
        pulse_cnt = 0;
        do_cycle(1'b1, "hold_credit");
        do_cycle(1'b1, "hold_credit");
        for (int i = 0; i < 20; i++) do_cycle(1'b0, "hold_gap");
        do_cycle(1'b1, "hold_credit");
        do_cycle(1'b0, "hold_credit");
        n_cmp++;
        if (pulse_cnt != 1) begin
            n_err++;
            $display("FAIL hold_credit_pulses: got %0d want 1", pulse_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_cycle(1'b1, "reset_mid");
        do_cycle(1'b1, "reset_mid");
        apply_reset(1, "reset_mid");
        pulse_cnt = 0;
        do_cycle(1'b1, "reset_mid_one");
        do_cycle(1'b0, "reset_mid_one");
        do_cycle(1'b1, "reset_mid_more");
        do_cycle(1'b1, "reset_mid_more");
        do_cycle(1'b0, "reset_mid_more");
        n_cmp++;
        if (pulse_cnt != 1) begin
            n_err++;
            $display("FAIL reset_mid_pulses: got %0d want 1", pulse_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            do_cycle(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, "random");
        end
        do_cycle(1'b0, "random_tail");
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        model_cnt = 0;
        pulse_cnt = 0;
        prev_cola = 1'b0;
        sys_rst_n = 1'b0;
        pi_money  = 1'b0;
        test_reset();
        test_separated();
        test_back_to_back();
        test_hold_credit();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
